// File: rtl/anfsqrt_pkg.sv
// rtl/anfsqrt_pkg.sv - shared constants, FSM state enum and 7-segment decode for the sqrt display path
package anfsqrt_pkg;

  localparam int DEF_WIDTH  = 11;
  localparam int DEF_DIGITS = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } fsm_state_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal nibbles cannot come out of the converter; they decode dark as a guard.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    logic [6:0] code;
    case (nibble)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/anfsqrt_bcd_disp_if.sv
// rtl/anfsqrt_bcd_disp_if.sv - valid/ready input handshake carrying one binary root
import anfsqrt_pkg::*;

interface anfsqrt_bcd_disp_if #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/anfsqrt_seg7_dec.sv
// rtl/anfsqrt_seg7_dec.sv - combinational nibble-plus-blank to 7-segment decoder
import anfsqrt_pkg::*;

module anfsqrt_seg7_dec (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : seg7_decode(nibble);

endmodule

// File: rtl/anfsqrt_bcd_disp.sv
// rtl/anfsqrt_bcd_disp.sv - sequential double-dabble binary-to-BCD converter with multiplexed 7-segment scan
import anfsqrt_pkg::*;

module anfsqrt_bcd_disp #(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DIGITS   = DEF_DIGITS,
  parameter  int SCAN_DIV = 256,
  parameter  int BLANK_LZ = 1,
  localparam int DSW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  anfsqrt_bcd_disp_if.slave       in_if,
  output logic [4*DIGITS-1:0]     bcd_out,
  output logic                    bcd_valid,
  output logic                    busy,
  output logic [6:0]              seg,
  output logic [DSW-1:0]          digit_sel
);

  localparam int         BW      = 4 * DIGITS;
  localparam int         CW      = $clog2(WIDTH + 1);
  localparam int         PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_SHIFT = SHIFT;

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    scratch;
  logic [CW-1:0]    bit_cnt;

  logic [BW-1:0]    scratch_adj;
  logic [BW-1:0]    scratch_nxt;
  logic [WIDTH-1:0] shift_nxt;

  logic [PW-1:0]    presc;
  logic [3:0]       digit_nib [DIGITS];
  logic [DIGITS-1:0] lz_blank;
  logic             higher_nz;

  assign in_if.in_ready = (state == S_IDLE);
  assign busy           = (state == S_SHIFT);

  // Add-3 is confined to each nibble; a nibble >= 5 never overflows past 8+.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign scratch_nxt = {scratch_adj[BW-2:0], shift_reg[WIDTH-1]};
  assign shift_nxt   = {shift_reg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (in_if.in_valid) begin
          shift_reg <= in_if.in_value;
          scratch   <= '0;
          bit_cnt   <= CW'(WIDTH);
          state     <= S_SHIFT;
        end
      end else begin
        scratch   <= scratch_nxt;
        shift_reg <= shift_nxt;
        bit_cnt   <= bit_cnt - CW'(1);
        // Publish only the fully converted value so the display never sees partials.
        if (bit_cnt == CW'(1)) begin
          bcd_out   <= scratch_nxt;
          bcd_valid <= 1'b1;
          state     <= S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      digit_sel <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc     <= '0;
      digit_sel <= (digit_sel == DSW'(DIGITS - 1)) ? '0 : digit_sel + DSW'(1);
    end else begin
      presc     <= presc + PW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digit_nib[i] = bcd_out[4*i +: 4];
    end
  end

  // A digit is a leading zero when it and everything above it are zero; digit 0 always shows.
  always_comb begin
    higher_nz = 1'b0;
    lz_blank  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_nz   = higher_nz | (bcd_out[4*i +: 4] != 4'd0);
      lz_blank[i] = (BLANK_LZ != 0) && (i != 0) && !higher_nz;
    end
  end

  anfsqrt_seg7_dec u_seg7_dec (
    .nibble (digit_nib[digit_sel]),
    .blank  (lz_blank[digit_sel]),
    .seg    (seg)
  );

endmodule

// File: tb/tb_anfsqrt_bcd_disp.sv
// tb/tb_anfsqrt_bcd_disp.sv - randomized self-checking bench for the BCD converter and display scanner
module tb_anfsqrt_bcd_disp;

  localparam int W  = 11;
  localparam int D  = 4;
  localparam int SD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  anfsqrt_bcd_disp_if #(.WIDTH(W)) in_if ();

  logic [4*D-1:0] bcd_out;
  logic           bcd_valid;
  logic           busy;
  logic [6:0]     seg;
  logic [1:0]     digit_sel;

  anfsqrt_bcd_disp #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (in_if),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  int vectors = 0;
  int errors  = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [6:0] seg_of(input int v, input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (d > 0 && v < p) return 7'h00;
    return seg_tab[(v / p) % 10];
  endfunction

  // Present one value for a single capture edge, then scramble in_value.
  task automatic start(input int v);
    in_if.in_valid = 1'b1;
    in_if.in_value = 11'(v);
    @(posedge clk);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    in_if.in_value = 11'($urandom);
  endtask

  task automatic test_convert(input int v);
    logic [15:0] prev;
    int n;
    prev = bcd_out;
    start(v);
    n = 0;
    while (bcd_valid !== 1'b1 && n < 40) begin
      vectors++;
      if (busy !== 1'b1 || bcd_out !== prev || in_if.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL shift_hold v=%0d cyc=%0d: busy=%b rdy=%b bcd=%h, required busy=1 rdy=0 bcd=%h",
                 v, n, busy, in_if.in_ready, bcd_out, prev);
      end
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 11) begin
      errors++;
      $display("FAIL latency v=%0d: %0d edges, required 11", v, n);
    end
    vectors++;
    if (bcd_out !== to_bcd(v) || in_if.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL result v=%0d: bcd=%h rdy=%b busy=%b, required bcd=%h rdy=1 busy=0",
               v, bcd_out, in_if.in_ready, busy, to_bcd(v));
    end
    @(negedge clk);
    vectors++;
    if (bcd_valid !== 1'b0 || bcd_out !== to_bcd(v)) begin
      errors++;
      $display("FAIL valid_pulse v=%0d: bcd_valid=%b bcd=%h, required 0 and %h", v, bcd_valid, bcd_out, to_bcd(v));
    end
  endtask

  task automatic test_reset();
    in_if.in_valid = 1'b0;
    in_if.in_value = '0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bcd_out !== 16'h0 || in_if.in_ready !== 1'b1 || busy !== 1'b0 || digit_sel !== 2'd0 || seg !== 7'h3F || bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: bcd=%h rdy=%b busy=%b sel=%0d seg=%h, required 0000 1 0 0 3f",
               bcd_out, in_if.in_ready, busy, digit_sel, seg);
    end
    #20 rst_n = 1'b1;
    @(negedge clk);
    test_convert(1234);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bcd_out !== 16'h0 || in_if.in_ready !== 1'b1 || busy !== 1'b0 || digit_sel !== 2'd0 || seg !== 7'h3F) begin
      errors++;
      $display("FAIL reset_async: bcd=%h rdy=%b busy=%b sel=%0d seg=%h, required 0000 1 0 0 3f",
               bcd_out, in_if.in_ready, busy, digit_sel, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      test_convert(int'($urandom_range(2047, 0)));
    end
  endtask

  task automatic test_display(input int v);
    logic [1:0] prev_sel;
    int k;
    int dd;
    test_convert(v);
    k = 0;
    do begin
      prev_sel = digit_sel;
      @(negedge clk);
      k++;
    end while (!(digit_sel == 2'd0 && prev_sel == 2'd3) && k < 40);
    vectors++;
    if (k >= 40) begin
      errors++;
      $display("FAIL scan_wrap v=%0d: digit_sel never wrapped 3->0, last=%0d required 0", v, digit_sel);
    end
    for (int j = 0; j < 20; j++) begin
      dd = (j / SD) % D;
      vectors++;
      if (digit_sel !== 2'(dd) || seg !== seg_of(v, dd)) begin
        errors++;
        $display("FAIL scan v=%0d cyc=%0d: sel=%0d seg=%h, required sel=%0d seg=%h",
                 v, j, digit_sel, seg, dd, seg_of(v, dd));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    in_if.in_valid = 1'b1;
    in_if.in_value = 11'd100;
    @(posedge clk);
    @(negedge clk);
    in_if.in_value = 11'd7;
    n = 0;
    while (bcd_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 11 || bcd_out !== 16'h0100 || in_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d bcd=%h rdy=%b, required 11 0100 1", n, bcd_out, in_if.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_capture: busy=%b, required 1", busy);
    end
    n = 1;
    while (bcd_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 12 || bcd_out !== 16'h0007) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d bcd=%h, required 12 0007", n, bcd_out);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int seen;
    start(2047);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bcd_out !== 16'h0 || in_if.in_ready !== 1'b1 || busy !== 1'b0 || bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset: bcd=%h rdy=%b busy=%b vld=%b, required 0000 1 0 0",
               bcd_out, in_if.in_ready, busy, bcd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 15; j++) begin
      if (bcd_valid === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 0 || bcd_out !== 16'h0) begin
      errors++;
      $display("FAIL midreset_quiet: activity cycles=%0d bcd=%h, required 0 and 0000", seen, bcd_out);
    end
    test_convert(1234);
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_value = '0;
    test_reset();
    test_convert(45);
    test_random();
    test_display(2047);
    test_display(5);
    test_display(0);
    test_display(int'($urandom_range(2047, 0)));
    test_back_to_back();
    test_mid_reset();
    test_convert(0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
